// File: rtl/mining_pkg.sv
// Shared types and default widths for the mining dispatcher and the hashing module.
package mining_pkg;

    localparam int NONCE_W_DEF = 32;
    localparam int HASH_W_DEF  = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CHECK,
        ST_ABORT
    } dispatch_state_t;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear, enable and a programmable rollover value.
module flex_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic             rollover_flag
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        // NOTE: default first so every path assigns count_d; otherwise a latch is inferred.
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            count_d = (count_q == rollover_val) ? '0 : count_q + 1'b1;
        end
    end

    // NOTE: non-blocking here so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/mining_dispatcher.sv
// Walks a nonce range, issues one hash per nonce, and stops on a hit, range end, timeout or abort.
module mining_dispatcher
    import mining_pkg::*;
#(
    parameter int NONCE_W = NONCE_W_DEF,
    parameter int HASH_W  = HASH_W_DEF,
    parameter int TIMEOUT = 200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [NONCE_W-1:0] nonce_start,
    input  logic [NONCE_W-1:0] nonce_end,
    input  logic [HASH_W-1:0]  target,
    input  logic               hash_done,
    input  logic [HASH_W-1:0]  hash_result,
    output logic               begin_hash,
    output logic               quit_hash,
    output logic [NONCE_W-1:0] nonce,
    output logic               busy,
    output logic               found,
    output logic [NONCE_W-1:0] golden_nonce,
    output logic               exhausted,
    output logic               timeout_err,
    output logic [NONCE_W-1:0] attempts
);

    localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    dispatch_state_t state_q, state_d;

    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [NONCE_W-1:0] end_q, end_d;
    logic [HASH_W-1:0]  target_q, target_d;
    logic [HASH_W-1:0]  hash_q, hash_d;
    logic [NONCE_W-1:0] golden_q, golden_d;
    logic [NONCE_W-1:0] attempts_q, attempts_d;
    logic               found_q, found_d;
    logic               exhausted_q, exhausted_d;
    logic               timeout_err_q, timeout_err_d;

    logic timer_expired;
    logic hash_hit;
    logic at_end;

    // Timer is zeroed while the hash is issued, so it reads TIMER_LAST in the TIMEOUT-th WAIT cycle.
    flex_counter #(.WIDTH(TIMER_W)) u_timer (
        .clk          (clk),
        .rst          (rst),
        .clear        (state_q == ST_ISSUE),
        .count_enable (state_q == ST_WAIT),
        .rollover_val (TIMER_LAST),
        .rollover_flag(timer_expired)
    );

    assign hash_hit = (hash_q < target_q);
    assign at_end   = (nonce_q == end_q);

    // Next-state logic; abort pre-empts both hash_done and the timer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_ISSUE;
            ST_ISSUE: state_d = abort ? ST_ABORT : ST_WAIT;
            ST_WAIT: begin
                if (abort)              state_d = ST_ABORT;
                else if (hash_done)     state_d = ST_CHECK;
                else if (timer_expired) state_d = ST_ABORT;
            end
            ST_CHECK: begin
                if (abort)                   state_d = ST_ABORT;
                else if (hash_hit || at_end) state_d = ST_IDLE;
                else                         state_d = ST_ISSUE;
            end
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        nonce_d       = nonce_q;
        end_d         = end_q;
        target_d      = target_q;
        hash_d        = hash_q;
        golden_d      = golden_q;
        attempts_d    = attempts_q;
        found_d       = found_q;
        exhausted_d   = exhausted_q;
        timeout_err_d = timeout_err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    nonce_d       = nonce_start;
                    end_d         = nonce_end;
                    target_d      = target;
                    attempts_d    = '0;
                    found_d       = 1'b0;
                    exhausted_d   = 1'b0;
                    timeout_err_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (!abort) begin
                    if (hash_done)          hash_d        = hash_result;
                    else if (timer_expired) timeout_err_d = 1'b1;
                end
            end
            ST_CHECK: begin
                if (!abort) begin
                    attempts_d = (&attempts_q) ? attempts_q : attempts_q + 1'b1;
                    if (hash_hit) begin
                        golden_d = nonce_q;
                        found_d  = 1'b1;
                    end else if (at_end) begin
                        exhausted_d = 1'b1;
                    end else begin
                        nonce_d = nonce_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            nonce_q       <= '0;
            golden_q      <= '0;
            attempts_q    <= '0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            nonce_q       <= nonce_d;
            golden_q      <= golden_d;
            attempts_q    <= attempts_d;
            found_q       <= found_d;
            exhausted_q   <= exhausted_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // NOTE: these wide datapath registers are always written before being read, so they carry no reset.
    always_ff @(posedge clk) begin
        end_q    <= end_d;
        target_q <= target_d;
        hash_q   <= hash_d;
    end

    always_comb begin
        begin_hash = 1'b0;
        quit_hash  = 1'b0;
        busy       = 1'b1;
        unique case (state_q)
            ST_IDLE:  busy       = 1'b0;
            ST_ISSUE: begin_hash = 1'b1;
            ST_ABORT: quit_hash  = 1'b1;
            default: ;
        endcase
    end

    assign nonce        = nonce_q;
    assign golden_nonce = golden_q;
    assign attempts     = attempts_q;
    assign found        = found_q;
    assign exhausted    = exhausted_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_mining_dispatcher.sv
// Directed bench for mining_dispatcher: hit, exhaustion, wrap, timeout, abort and reset scenarios.
module tb_mining_dispatcher;

    localparam int NONCE_W = 32;
    localparam int HASH_W  = 256;
    localparam int TIMEOUT = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [NONCE_W-1:0] nonce_start = '0;
    logic [NONCE_W-1:0] nonce_end = '0;
    logic [HASH_W-1:0]  target = '0;
    logic               hash_done = 1'b0;
    logic [HASH_W-1:0]  hash_result = '0;
    logic               begin_hash;
    logic               quit_hash;
    logic [NONCE_W-1:0] nonce;
    logic               busy;
    logic               found;
    logic [NONCE_W-1:0] golden_nonce;
    logic               exhausted;
    logic               timeout_err;
    logic [NONCE_W-1:0] attempts;

    int checks = 0;
    int errors = 0;
    int begin_cnt = 0;
    int quit_cnt = 0;
    int snap_begin;
    int snap_quit;

    mining_dispatcher #(
        .NONCE_W(NONCE_W),
        .HASH_W (HASH_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .nonce_start (nonce_start),
        .nonce_end   (nonce_end),
        .target      (target),
        .hash_done   (hash_done),
        .hash_result (hash_result),
        .begin_hash  (begin_hash),
        .quit_hash   (quit_hash),
        .nonce       (nonce),
        .busy        (busy),
        .found       (found),
        .golden_nonce(golden_nonce),
        .exhausted   (exhausted),
        .timeout_err (timeout_err),
        .attempts    (attempts)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (begin_hash) begin_cnt <= begin_cnt + 1;
        if (quit_hash)  quit_cnt  <= quit_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] s, input logic [31:0] e, input logic [HASH_W-1:0] t);
        nonce_start = s;
        nonce_end   = e;
        target      = t;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    task automatic wait_begin();
        int n = 0;
        while (!begin_hash && n < 20) begin
            tick();
            n++;
        end
        check_bit("begin_seen", begin_hash, 1'b1);
    endtask

    // Hashing-module model: answer the issued nonce one cycle into WAIT, then land on CHECK+1.
    task automatic serve(input logic [HASH_W-1:0] r, input logic [31:0] exp_nonce);
        wait_begin();
        check_word("issue_nonce", nonce, exp_nonce);
        tick();
        hash_result = r;
        hash_done   = 1'b1;
        tick();
        hash_done   = 1'b0;
        hash_result = '0;
        tick();
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check_bit ("rst_busy", busy, 1'b0);
        check_bit ("rst_begin", begin_hash, 1'b0);
        check_bit ("rst_quit", quit_hash, 1'b0);
        check_bit ("rst_found", found, 1'b0);
        check_bit ("rst_exhausted", exhausted, 1'b0);
        check_bit ("rst_timeout", timeout_err, 1'b0);
        check_word("rst_nonce", nonce, 32'h0);
        check_word("rst_golden", golden_nonce, 32'h0);
        check_word("rst_attempts", attempts, 32'h0);
        rst = 1'b0;
        tick();

        // Hit on the third nonce
        do_start(32'h10, 32'h20, 256'h100);
        check_bit("start_to_issue", begin_hash, 1'b1);
        check_bit("busy_in_issue", busy, 1'b1);
        serve(256'h500, 32'h10);
        check_bit("issue_at_d2", begin_hash, 1'b1);
        serve(256'h400, 32'h11);
        serve(256'h0FF, 32'h12);
        check_bit ("hit_found", found, 1'b1);
        check_bit ("hit_busy", busy, 1'b0);
        check_word("hit_golden", golden_nonce, 32'h12);
        check_word("hit_attempts", attempts, 32'd3);
        check_bit ("hit_exhausted", exhausted, 1'b0);
        tick();

        // Exhausted range, including an equal-to-target miss
        snap_begin = begin_cnt;
        do_start(32'h5, 32'h7, 256'h100);
        serve(256'h100, 32'h5);
        serve(256'h200, 32'h6);
        serve({HASH_W{1'b1}}, 32'h7);
        check_bit ("exh_exhausted", exhausted, 1'b1);
        check_bit ("exh_found", found, 1'b0);
        check_bit ("exh_busy", busy, 1'b0);
        check_word("exh_nonce", nonce, 32'h7);
        check_word("exh_attempts", attempts, 32'd3);
        check_word("exh_golden_kept", golden_nonce, 32'h12);
        check_word("exh_begin_pulses", 32'(begin_cnt - snap_begin), 32'd3);
        tick();

        // Wrap-around through all-ones
        do_start(32'hFFFF_FFFE, 32'h0000_0001, 256'h100);
        serve(256'h1000, 32'hFFFF_FFFE);
        serve(256'h1000, 32'hFFFF_FFFF);
        serve(256'h1000, 32'h0000_0000);
        serve(256'h1000, 32'h0000_0001);
        check_bit ("wrap_exhausted", exhausted, 1'b1);
        check_bit ("wrap_found", found, 1'b0);
        check_word("wrap_attempts", attempts, 32'd4);
        tick();

        // Timeout with no response
        snap_quit = quit_cnt;
        do_start(32'h0, 32'h10, 256'h100);
        check_bit("to_begin", begin_hash, 1'b1);
        repeat (TIMEOUT) tick();
        check_bit("to_quit_early", quit_hash, 1'b0);
        check_bit("to_err_early", timeout_err, 1'b0);
        tick();
        check_bit("to_quit", quit_hash, 1'b1);
        check_bit("to_err", timeout_err, 1'b1);
        check_bit("to_busy_in_abort", busy, 1'b1);
        tick();
        check_bit ("to_busy_after", busy, 1'b0);
        check_bit ("to_err_sticky", timeout_err, 1'b1);
        check_word("to_quit_pulses", 32'(quit_cnt - snap_quit), 32'd1);
        tick();

        // Abort and a hitting hash_done in the same cycle
        do_start(32'h20, 32'h30, 256'h100);
        check_bit("ab_err_cleared", timeout_err, 1'b0);
        tick();
        abort       = 1'b1;
        hash_done   = 1'b1;
        hash_result = 256'h5;
        tick();
        abort       = 1'b0;
        hash_done   = 1'b0;
        hash_result = '0;
        check_bit("ab_quit", quit_hash, 1'b1);
        check_bit("ab_found", found, 1'b0);
        check_bit("ab_err", timeout_err, 1'b0);
        tick();
        check_bit ("ab_busy", busy, 1'b0);
        check_bit ("ab_found_after", found, 1'b0);
        check_word("ab_attempts", attempts, 32'd0);
        tick();

        // Start while busy is ignored, then reset mid-search
        do_start(32'h40, 32'h50, 256'h100);
        serve(256'h900, 32'h40);
        check_bit ("sb_issue", begin_hash, 1'b1);
        check_word("sb_nonce_issue", nonce, 32'h41);
        nonce_start = 32'h80;
        nonce_end   = 32'h41;
        target      = 256'h1000;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        check_word("sb_nonce_wait", nonce, 32'h41);
        hash_result = 256'h900;
        hash_done   = 1'b1;
        tick();
        hash_done   = 1'b0;
        hash_result = '0;
        tick();
        check_bit ("sb_continue", begin_hash, 1'b1);
        check_word("sb_next_nonce", nonce, 32'h42);
        check_bit ("sb_not_exhausted", exhausted, 1'b0);
        check_bit ("sb_not_found", found, 1'b0);
        check_word("sb_attempts", attempts, 32'd2);
        tick();
        snap_quit = quit_cnt;
        rst = 1'b1;
        tick();
        check_bit ("mr_busy", busy, 1'b0);
        check_bit ("mr_quit", quit_hash, 1'b0);
        check_bit ("mr_begin", begin_hash, 1'b0);
        check_word("mr_nonce", nonce, 32'h0);
        check_word("mr_attempts", attempts, 32'h0);
        rst = 1'b0;
        tick();
        tick();
        check_bit ("mr_idle", busy, 1'b0);
        check_word("mr_no_quit", 32'(quit_cnt - snap_quit), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mining_dispatcher.md
# mining_dispatcher

Initiator side of the hashing-module handshake: walks a nonce range, issues one `begin_hash` per nonce, and waits for `hash_done`. It compares each returned hash against the target and either records a golden nonce or moves to the next nonce. It sits between the host/register interface and the hashing module controller. It drives `begin_hash`/`quit_hash` and consumes `hash_done`/result.

## Interface
Parameters:
- NONCE_W, 32, nonce width
- HASH_W, 256, hash/target width
- TIMEOUT, 200, max cycles from `begin_hash` to `hash_done` before abort

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high. One clock domain only; all state updates on rising `clk`.
- start  in  1  one-cycle request to begin a search; honoured only in IDLE
- abort  in  1  host cancel; honoured in ISSUE/WAIT/CHECK
- nonce_start  in  NONCE_W  first nonce, sampled with `start`
- nonce_end  in  NONCE_W  last nonce (inclusive), sampled with `start`
- target  in  HASH_W  difficulty target, sampled with `start`
- hash_done  in  1  one-cycle pulse from hashing module
- hash_result  in  HASH_W  valid only while `hash_done`=1
- begin_hash  out  1  one-cycle pulse to hashing module
- quit_hash  out  1  one-cycle pulse cancelling the hash in flight
- nonce  out  NONCE_W  nonce under test; stable from `begin_hash` through `hash_done`
- busy  out  1  high in every state except IDLE
- found  out  1  sticky; a golden nonce was found
- golden_nonce  out  NONCE_W  nonce whose hash < target
- exhausted  out  1  sticky; range completed with no hit
- timeout_err  out  1  sticky; hashing module failed to respond
- attempts  out  NONCE_W  completed hashes this search; saturates at all-ones

## Operation
States: IDLE, ISSUE, WAIT, CHECK, ABORT.

- **IDLE:**
  - On `start`: latch `nonce_start`→nonce, `nonce_end`, and `target`.
  - Clear found/exhausted/timeout_err/attempts. `golden_nonce` keeps its old value until the next hit.
  - Go to ISSUE.
  - `hash_done`/`abort` in IDLE are ignored.
- **ISSUE:** `begin_hash`=1 (Moore output); clear timeout timer; go to WAIT.
- **WAIT:**
  - Timer increments each cycle.
  - On `hash_done`: capture `hash_result`; go to CHECK.
  - If the timer reaches TIMEOUT-1 without `hash_done`: set timeout_err; go to ABORT.
- **CHECK:** unsigned compare, captured hash strictly < target.
  - attempts+1 (saturating).
  - Hit: golden_nonce←nonce, found←1, go to IDLE.
  - Else if nonce == latched end: exhausted←1, go to IDLE.
  - Else: nonce←nonce+1 (mod 2^NONCE_W), go to ISSUE.
- **ABORT:** `quit_hash`=1 for one cycle; go to IDLE.
- **Priority:**
  - `abort` beats `hash_done` and timeout in the same cycle; it still goes to ABORT.
  - A timeout from `abort` does not set timeout_err.
- **Start while busy:** ignored; latched range and target unchanged.
- **Wrap-around:** nonce_end < nonce_start is legal. The nonce wraps through all-ones to 0 and stops at end. nonce_start == nonce_end gives exactly one attempt.
- **Equality:** hash == target is a miss.

## Timing
- **Reset values:** state IDLE; nonce 0; golden_nonce 0; attempts 0. All 1-bit outputs 0.
- **Reset mid-search:** returns to IDLE next edge. No `quit_hash` is emitted; the hashing module is reset by the same `rst`.
- **Start to first issue:** `start` sampled at edge k; `begin_hash` high during cycle k+1.
- **Per-nonce overhead:** `hash_done` in cycle d gives CHECK in d+1 and the next `begin_hash` in d+2.
- **Result visibility:** found/exhausted and busy=0 are visible from cycle d+2.
- **Timeout:** `begin_hash` in cycle i with no response gives timeout_err=1 and `quit_hash` in cycle i+TIMEOUT+1, and busy=0 in i+TIMEOUT+2.
- **Abort:** `abort` in cycle a gives `quit_hash` in a+1 and busy=0 in a+2.

## Structure
- **Package `mining_pkg`:** state enum `dispatch_state_t`, plus default NONCE_W/HASH_W constants shared with the hashing module.
- **Sub-module:** `flex_counter` (parameterised width, clear, count_enable, rollover_val, rollover_flag) implements the WAIT timeout timer.
- **Hash comparator:** stays inline.

## Test plan
- **Hit on third nonce:** start 0x10..0x20, target 0x100; hashing model returns 0x500, 0x400, 0x0FF → found=1, golden_nonce=0x12, attempts=3, exhausted=0.
- **Exhausted range:** start 5..7, all results ≥ target → exactly 3 `begin_hash` pulses, exhausted=1, found=0, final nonce=7.
- **Wrap-around:** start 0xFFFFFFFE..0x00000001, no hits → issued nonces FFFFFFFE, FFFFFFFF, 0, 1; exhausted=1, attempts=4.
- **Timeout:** TIMEOUT=8, model never responds → `quit_hash` 9 cycles after `begin_hash`, timeout_err=1, busy=0 next cycle.
- **Abort vs done:** `abort` and `hash_done` (result < target) in the same cycle → `quit_hash` pulse, found=0, timeout_err=0, busy=0.
- **Start while busy, then mid-search reset:** second `start` with a different range is ignored (nonce continues from the first range); `rst` in WAIT → all outputs 0 next cycle, no `quit_hash`.
